leds_ctrl: RTL and testbench
============================

Name: leds_ctrl

Overview:
Parametrised N-channel button-to-LED controller; successor to the combinational button/LED block.
Each button is synchronised, debounced and edge-detected. Each press steps its channel through four LED modes: OFF, ON, BLINK, DIM (PWM).
Sits at the board top level between the raw button pins and the LED pins; one instance serves all channels.

Parameters:
N, 2, number of button/LED channels
DEBOUNCE, 1000, consecutive clk cycles a synchronised input must differ from its stable value before it is accepted (>=1)
BLINK_DIV, 6000000, clk cycles per blink half-period (>=2)
PWM_BITS, 4, width of the shared PWM counter
DUTY, 4, DIM-mode on-count per PWM period (0..2^PWM_BITS)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
but  in  N  raw asynchronous buttons, active-high
led  out  N  LED drives, registered, active-high
press  out  N  one-cycle pulse per accepted press (debounced rising edge)
mode  out  2N  current mode per channel; channel i occupies bits [2i+1:2i]

Behaviour:
- Reset (async assert, sync release): sync flops 0, stable 0, debounce counters 0, mode OFF, blink prescaler 0, blink phase 0, PWM counter 0, led 0, press 0.
- Synchroniser: two flops per channel.
- Debounce, per channel:
  - counter clears whenever the synchronised input equals the stable value.
  - otherwise the counter increments; when it reaches DEBOUNCE-1, stable takes the synchronised value and the counter clears.
  - a glitch shorter than DEBOUNCE cycles never changes stable.
- press[i]: asserted for exactly one cycle, the cycle after stable[i] goes 0->1. Release (1->0) produces no pulse.
- Latency: a clean but rise to press pulse is 2 + DEBOUNCE + 1 cycles.
- Mode FSM, per channel, 2-bit: OFF=0 -> ON=1 -> BLINK=2 -> DIM=3 -> OFF.
  - advances on the cycle press[i] is high; mode output updates the following cycle.
  - wraps DIM->OFF; no other transitions.
  - channels are independent; simultaneous presses on several channels each advance their own FSM.
- Blink prescaler, shared:
  - counts 0..BLINK_DIV-1 and wraps.
  - blink phase toggles on each wrap, so the blink period is 2*BLINK_DIV cycles.
  - free-running from reset, independent of mode; entering BLINK does not restart it.
- PWM counter, shared: PWM_BITS wide, free-running, wraps at 2^PWM_BITS-1 -> 0.
- led[i] registered, one cycle after mode / phase / counter:
  - OFF -> 0
  - ON -> 1
  - BLINK -> blink phase
  - DIM -> (pwm_cnt < DUTY)
  - DUTY=0 gives constant 0; DUTY=2^PWM_BITS gives constant 1. The comparison uses PWM_BITS+1 bits.
- Held button: one press only, no auto-repeat.
- Reset asserted mid-operation: every state returns to its reset value immediately; the first press after release selects ON.
- Counter widths: sized with $clog2 of DEBOUNCE and BLINK_DIV (minimum 1 bit). No overflow is possible.

Decomposition:
- Shared include file holds the mode encodings as named constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_DIM) so benches decode the mode port symbolically.
- One sub-module, led_debounce: per-channel synchroniser, debounce counter and rising-edge detector. Parameter DEBOUNCE; ports clk, rst_n, but, stable, press.
- leds_ctrl instantiates N led_debounce instances in a generate loop. It contains the mode FSMs, shared blink prescaler, shared PWM counter and output registers.

Test Plan:
Bench parameters: N=2, DEBOUNCE=4, BLINK_DIV=4, PWM_BITS=3, DUTY=2.
1. Reset: hold rst_n=0 with but=2'b11 -> led=0, press=0, mode=0 throughout; after release, press[0] and press[1] each pulse once, 7 cycles after release.
2. Glitch: but[0] high for 3 cycles, then low -> no press pulse, mode[1:0] stays 0, led[0]=0.
3. Mode cycle: four clean presses on but[0], each held 10 cycles, gaps of 10 cycles:
   - mode[1:0] goes 1, 2, 3, 0.
   - in ON, led[0] is constant 1.
   - in BLINK, led[0] toggles every 4 cycles.
   - in DIM, led[0] is high 2 of every 8 cycles.
   - channel 1 remains OFF throughout.
4. Simultaneous presses: but=2'b11 rising together -> press=2'b11 in the same cycle; both modes become 1 on the next cycle.
5. Held button: but[1] held high for 100 cycles -> exactly one press[1] pulse; mode[3:2]=1.
6. Reset mid-BLINK: drive channel 0 into BLINK, pulse rst_n low for 1 cycle -> led, mode and the prescalers clear asynchronously; the next press gives mode[1:0]=1 and led[0]=1.

Source files
------------

// File: rtl/leds_ctrl_pkg.sv
// Shared definitions for the button-to-LED controller: mode encodings and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package leds_ctrl_pkg;

   // Per-channel LED mode; one press advances to the next entry, DIM wraps to OFF.
   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_DIM   = 2'd3
   } mode_t;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Press-driven mode sequence: OFF -> ON -> BLINK -> DIM -> OFF.
   function automatic mode_t next_mode(input mode_t m);
      mode_t r;
      case (m)
         MODE_OFF:   r = MODE_ON;
         MODE_ON:    r = MODE_BLINK;
         MODE_BLINK: r = MODE_DIM;
         default:    r = MODE_OFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_debounce.sv
// One button channel: 2-flop synchroniser, debounce filter and registered rising-edge pulse.
// Latency: clean but rise to press pulse is 2 + DEBOUNCE + 1 clk cycles.
// Backpressure: none; press is a one-cycle pulse the consumer must take when it appears.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   but        : raw asynchronous button, active-high
//   stable     : debounced button level
//   press      : one-cycle pulse, the cycle after stable goes 0->1
module led_debounce
   import leds_ctrl_pkg::*;
#(
   parameter int DEBOUNCE = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic but,
   output logic stable,
   output logic press
);

   localparam int            CW       = cnt_width(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic          sync1;
   logic          sync2;
   logic          stable_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync1 <= but;
         sync2 <= sync1;

         // The counter only runs while the synchronised input disagrees with
         // the accepted level; any return to agreement restarts the count, so a
         // disagreement must persist DEBOUNCE consecutive cycles to be accepted.
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end

         // Edge detect on the accepted level; release edges are ignored.
         stable_q <= stable;
         press    <= stable & ~stable_q;
      end
   end

endmodule

// File: rtl/leds_ctrl.sv
// N-channel button-to-LED controller: each accepted press steps its channel OFF->ON->BLINK->DIM.
// Latency: press pulse to mode update 1 cycle; mode/blink phase/PWM count to led 1 cycle.
// Backpressure: none; all outputs are free-running registered levels or single-cycle pulses.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   but[N]     : raw asynchronous buttons, active-high
//   led[N]     : registered LED drives, active-high
//   press[N]   : one-cycle pulse per accepted (debounced rising-edge) press
//   mode[2N]   : current mode per channel, channel i at bits [2i+1:2i]
module leds_ctrl
   import leds_ctrl_pkg::*;
#(
   parameter int N         = 2,
   parameter int DEBOUNCE  = 1000,
   parameter int BLINK_DIV = 6000000,
   parameter int PWM_BITS  = 4,
   parameter int DUTY      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     but,
   output logic [N-1:0]     led,
   output logic [N-1:0]     press,
   output logic [2*N-1:0]   mode
);

   localparam int              BW         = cnt_width(BLINK_DIV);
   localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
   // One extra bit so DUTY = 2^PWM_BITS is representable and yields a constant-on LED.
   localparam logic [PWM_BITS:0] DUTY_V   = (PWM_BITS + 1)'(DUTY);

   // Debounced levels are not consumed here; only the press pulses drive the FSMs.
   logic [N-1:0]        stable_unused;
   mode_t               mode_q [N];
   logic [BW-1:0]       blink_cnt;
   logic                blink_phase;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                dim_on;

   // ---------------- per-channel input conditioning ----------------
   for (genvar g = 0; g < N; g++) begin : g_chan
      led_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_debounce (
         .clk    (clk),
         .rst_n  (rst_n),
         .but    (but[g]),
         .stable (stable_unused[g]),
         .press  (press[g])
      );

      assign mode[2*g +: 2] = mode_q[g];
   end

   // ---------------- mode FSMs, one per channel ----------------
   // Each channel advances independently on its own press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            mode_q[i] <= MODE_OFF;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (press[i]) begin
               mode_q[i] <= next_mode(mode_q[i]);
            end
         end
      end
   end

   // ---------------- shared blink prescaler ----------------
   // Free-running from reset; a channel entering BLINK joins the current phase
   // rather than restarting it, so all blinking channels stay in step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // ---------------- shared PWM counter ----------------
   // Natural binary wrap at 2^PWM_BITS-1 -> 0 gives the PWM period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   assign dim_on = ({1'b0, pwm_cnt} < DUTY_V);

   // ---------------- registered LED drives ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            case (mode_q[i])
               MODE_OFF:   led[i] <= 1'b0;
               MODE_ON:    led[i] <= 1'b1;
               MODE_BLINK: led[i] <= blink_phase;
               MODE_DIM:   led[i] <= dim_on;
               default:    led[i] <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_leds_ctrl.sv
// Scoreboard bench for leds_ctrl with N=2, DEBOUNCE=4, BLINK_DIV=4, PWM_BITS=3, DUTY=2.
// Stimulus pushes each expected press (vector, cycle, resulting mode) into a queue;
// an independent monitor pops and compares whenever the DUT raises a press pulse.
module tb_leds_ctrl;
   import leds_ctrl_pkg::*;

   localparam int N         = 2;
   localparam int DEBOUNCE  = 4;
   localparam int BLINK_DIV = 4;
   localparam int PWM_BITS  = 3;
   localparam int DUTY      = 2;
   localparam int PRESS_LAT = 7;   // 2 sync + 4 debounce + 1 edge register

   logic           clk   = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   but   = '0;
   logic [N-1:0]   led;
   logic [N-1:0]   press;
   logic [2*N-1:0] mode;

   leds_ctrl #(
      .N         (N),
      .DEBOUNCE  (DEBOUNCE),
      .BLINK_DIV (BLINK_DIV),
      .PWM_BITS  (PWM_BITS),
      .DUTY      (DUTY)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .but   (but),
      .led   (led),
      .press (press),
      .mode  (mode)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] vec;
      int         cyc;
      logic [3:0] mode;
   } exp_t;

   exp_t       q[$];
   int         n_pass   = 0;
   int         n_total  = 0;
   logic [3:0] exp_mode = '0;
   int         last_rel = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   function automatic logic [1:0] bump(input logic [1:0] m);
      case (m)
         2'd0:    return MODE_ON;
         2'd1:    return MODE_BLINK;
         2'd2:    return MODE_DIM;
         default: return MODE_OFF;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      repeat (hold) tick();
      rst_n    = 1'b1;
      last_rel = cyc;
      exp_mode = '0;
   endtask

   // Raise the given buttons now, release after 'hold' cycles, run 'total' cycles,
   // recording led[rch] at cycle k+i into rec[i].
   task automatic press_watch(input logic [1:0] chans, input int hold, input int total,
                              input int rch, output logic [63:0] rec, output int k);
      exp_t e;
      k   = cyc;
      but = but | chans;
      for (int c = 0; c < N; c++)
         if (chans[c]) exp_mode[2*c +: 2] = bump(exp_mode[2*c +: 2]);
      e.vec  = chans;
      e.cyc  = k + PRESS_LAT;
      e.mode = exp_mode;
      q.push_back(e);
      rec = '0;
      for (int i = 0; i < total; i++) begin
         @(negedge clk);
         if (i < 64) rec[i] = led[rch];
         @(posedge clk);
         #1;
         if (i + 1 == hold) but = but & ~chans;
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (press != '0) begin
            if (q.size() == 0) begin
               chk("unexpected_press", press, 0);
            end else begin
               e = q.pop_front();
               chk("press_vec", press, e.vec);
               chk("press_cycle", cyc, e.cyc);
               @(negedge clk);
               chk("mode_after_press", mode, e.mode);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] rec;
      int          k;
      int          dd;
      logic [1:0]  seq [4];
      seq[0] = MODE_ON; seq[1] = MODE_BLINK; seq[2] = MODE_DIM; seq[3] = MODE_OFF;

      // 1. Reset with both buttons held.
      but = 2'b11;
      #1 rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_outputs", {led, press, mode}, 0);
      end
      tick();
      rst_n    = 1'b1;
      last_rel = cyc;
      begin
         exp_t e;
         e.vec = 2'b11; e.cyc = cyc + PRESS_LAT; e.mode = 4'b0101;
         q.push_back(e);
         exp_mode = 4'b0101;
      end
      repeat (15) tick();
      but = 2'b00;
      repeat (15) tick();
      do_reset(3);
      repeat (5) tick();

      // 2. Three-cycle glitch: one short of the debounce window.
      but[0] = 1'b1;
      repeat (3) tick();
      but[0] = 1'b0;
      repeat (20) tick();
      chk("glitch_mode", mode, 0);
      chk("glitch_led0", led[0], 0);

      // 3. Mode cycle on channel 0.
      for (int p = 0; p < 4; p++) begin
         press_watch(2'b01, 10, 30, 0, rec, k);
         chk("mode_seq", mode[1:0], seq[p]);
         for (int t = 9; t < 29; t++) begin
            dd = k + t - 1 - last_rel;
            case (p)
               0: chk("on_led", rec[t], 1);
               1: chk("blink_led", rec[t], (dd / BLINK_DIV) % 2);
               2: chk("dim_led", rec[t], ((dd % (1 << PWM_BITS)) < DUTY) ? 1 : 0);
               default: chk("off_led", rec[t], 0);
            endcase
         end
         chk("ch1_led_off", led[1], 0);
      end

      // 4. Simultaneous presses.
      press_watch(2'b11, 10, 30, 0, rec, k);
      chk("simul_mode", mode, 4'b0101);

      // 5. Held button: single press only.
      do_reset(3);
      repeat (5) tick();
      press_watch(2'b10, 100, 120, 1, rec, k);
      chk("held_mode1", mode[3:2], MODE_ON);

      // 6. Reset in the middle of BLINK.
      do_reset(3);
      repeat (5) tick();
      press_watch(2'b01, 10, 30, 0, rec, k);
      press_watch(2'b01, 10, 25, 0, rec, k);
      chk("pre_reset_blink", mode[1:0], MODE_BLINK);
      rst_n = 1'b0;
      #1;
      chk("async_led_clear", led, 0);
      chk("async_mode_clear", mode, 0);
      tick();
      rst_n    = 1'b1;
      last_rel = cyc;
      exp_mode = '0;
      press_watch(2'b01, 10, 30, 0, rec, k);
      for (int t = 9; t < 29; t++) chk("post_reset_on_led", rec[t], 1);
      press_watch(2'b01, 10, 30, 0, rec, k);
      for (int t = 9; t < 29; t++) begin
         dd = k + t - 1 - last_rel;
         chk("post_reset_blink_phase", rec[t], (dd / BLINK_DIV) % 2);
      end

      repeat (5) tick();
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
